// File: rtl/seg_scan.sv
// seg_scan: time-multiplexed hex display scanner with frame-synchronous value update.
// A prescaler steps the selected digit every DIV cycles. A loaded value is staged
// and copied into the display register only when the scan wraps back to digit 0,
// so a frame never shows a mix of old and new digits. ackO pulses the cycle after
// the copy.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits
// (digit 0 is always shown).
module seg_scan #(
    parameter int DIGITS = 8,
    parameter int DIV    = 50000
) (
    input  logic                  clkI,
    input  logic                  rst_nI,
    input  logic [4*DIGITS-1:0]   valueI,
    input  logic                  loadI,
    output logic                  ackO,
    output logic [3:0]            numO,
    output logic [DIGITS-1:0]     selO
);

    localparam int CW = $clog2(DIV);
    localparam int IW = $clog2(DIGITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [CW-1:0]          cnt;
    logic [IW-1:0]          idx;
    logic [DIGITS-1:0][3:0] disp;
    logic [DIGITS-1:0][3:0] stage;
    logic                   pending;
    logic                   ack;
    logic                   tick;
    logic                   apply;

    assign tick  = (cnt == CNT_LAST);
    assign apply = tick && (idx == IDX_LAST) && pending;
    assign ackO  = ack;

    // Prescaler and digit index: idx advances once every DIV cycles and wraps per frame.
    always_ff @(posedge clkI or negedge rst_nI) begin
        if (!rst_nI) begin
            cnt <= '0;
            idx <= '0;
        end else if (tick) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Staging and display: the latest load wins; the copy happens only on the frame-wrap tick.
    always_ff @(posedge clkI or negedge rst_nI) begin
        if (!rst_nI) begin
            disp    <= '0;
            stage   <= '0;
            pending <= 1'b0;
            ack     <= 1'b0;
        end else begin
            ack <= apply;
            if (apply) begin
                disp <= stage;
            end
            if (loadI) begin
                stage   <= valueI;
                pending <= 1'b1;
            end else if (apply) begin
                pending <= 1'b0;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] lead;

    // lead[k] is set when digit k and every digit above it are zero.
    always_comb begin
        lead = '0;
        lead[DIGITS-1] = (disp[DIGITS-1] == 4'h0);
        for (int k = DIGITS - 2; k >= 0; k--) begin
            lead[k] = lead[k+1] && (disp[k] == 4'h0);
        end
    end
`endif

    // Output decode, fed only from the idx and display registers.
    always_comb begin
        numO = disp[idx];
        selO = ~(DIGITS'(1) << idx);
`ifdef LEADING_ZERO_BLANK_EN
        if ((idx != '0) && lead[idx]) begin
            selO = '1;
        end
`endif
    end

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: directed scenarios plus random loads for seg_scan (DIGITS=4, DIV=4).
// Expected outputs come from a frame-level model: the slot and frame position are
// derived from the number of cycles since reset, and the staged value is applied
// whenever the last cycle of a frame completes with a value pending.
module tb_seg_scan;

    localparam int DIGITS = 4;
    localparam int DIV    = 4;
    localparam int FRAME  = DIGITS * DIV;

    logic        clkI;
    logic        rst_nI;
    logic [15:0] valueI;
    logic        loadI;
    logic        ackO;
    logic [3:0]  numO;
    logic [3:0]  selO;

    int nChecks = 0;
    int nFails  = 0;
    int ackSeen = 0;

    // Reference model state.
    int          mT;
    logic [15:0] mDisp;
    logic [15:0] mStage;
    logic        mPend;
    logic        mAck;

    seg_scan #(.DIGITS(DIGITS), .DIV(DIV)) dut (
        .clkI   (clkI),
        .rst_nI (rst_nI),
        .valueI (valueI),
        .loadI  (loadI),
        .ackO   (ackO),
        .numO   (numO),
        .selO   (selO)
    );

    // Free-running clock, period 10.
    initial begin
        clkI = 1'b0;
        forever #5 clkI = ~clkI;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("[TB] FAIL %s at t=%0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic modelReset();
        mT     = 0;
        mDisp  = '0;
        mStage = '0;
        mPend  = 1'b0;
        mAck   = 1'b0;
    endtask

    // Expected outputs for the current model state.
    task automatic checkAll();
        int          slot;
        logic [3:0]  expSel;
        logic [3:0]  expNum;
        slot   = (mT / DIV) % DIGITS;
        expNum = 4'((mDisp >> (4 * slot)) & 16'hF);
        expSel = ~(4'b0001 << slot);
`ifdef LEADING_ZERO_BLANK_EN
        if (slot > 0 && (mDisp >> (4 * slot)) == 16'h0) expSel = 4'b1111;
`endif
        checkOutput("num", 32'(numO), 32'(expNum));
        checkOutput("sel", 32'(selO), 32'(expSel));
        checkOutput("ack", 32'(ackO), 32'(mAck));
    endtask

    // One clock cycle with an optional load, then model update and output check.
    task automatic applyStimulus(input logic ld, input logic [15:0] v);
        bit wrapEdge;
        bit doApply;
        loadI  = ld;
        valueI = v;
        @(posedge clkI);
        wrapEdge = ((mT % FRAME) == FRAME - 1);
        doApply  = wrapEdge && mPend;
        mAck     = doApply;
        if (doApply) mDisp = mStage;
        if (ld) begin
            mStage = v;
            mPend  = 1'b1;
        end else if (doApply) begin
            mPend = 1'b0;
        end
        mT++;
        #1;
        loadI = 1'b0;
        if (ackO) ackSeen++;
        checkAll();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, valueI);
    endtask

    // Asynchronous reset pulse away from the clock edge; outputs must clear at once.
    task automatic pulseReset();
        @(negedge clkI);
        #2 rst_nI = 1'b0;
        #1;
        checkOutput("rst_num", 32'(numO), 32'h0);
        checkOutput("rst_sel", 32'(selO), 32'hE);
        checkOutput("rst_ack", 32'(ackO), 32'h0);
        modelReset();
        @(negedge clkI);
        @(negedge clkI);
        rst_nI = 1'b1;
    endtask

    initial begin
        rst_nI = 1'b1;
        loadI  = 1'b0;
        valueI = '0;
        modelReset();
        #3 rst_nI = 1'b0;
        #1;
        checkOutput("init_num", 32'(numO), 32'h0);
        checkOutput("init_sel", 32'(selO), 32'hE);
        checkOutput("init_ack", 32'(ackO), 32'h0);
        @(negedge clkI);
        rst_nI = 1'b1;

        // Idle scan after reset.
        ackSeen = 0;
        idle(16);
        checkOutput("idle_acks", 32'(ackSeen), 32'd0);

        // Mid-frame load, applied at the next frame boundary.
        ackSeen = 0;
        idle(6);
        applyStimulus(1'b1, 16'h1234);
        idle(26);
        checkOutput("load_acks", 32'(ackSeen), 32'd1);

        // Overwrite while pending: only the latest value shows, one ack.
        ackSeen = 0;
        idle(2);
        applyStimulus(1'b1, 16'hAAAA);
        idle(3);
        applyStimulus(1'b1, 16'h5555);
        idle(24);
        checkOutput("ovr_acks", 32'(ackSeen), 32'd1);

        // Load coinciding with the applying tick.
        ackSeen = 0;
        applyStimulus(1'b1, 16'h0F0F);
        while ((mT % FRAME) != FRAME - 1) applyStimulus(1'b0, valueI);
        applyStimulus(1'b1, 16'hBEEF);
        idle(34);
        checkOutput("coinc_acks", 32'(ackSeen), 32'd2);

        // Reset mid-frame with a value pending: discarded, no ack.
        pulseReset();
        ackSeen = 0;
        idle(5);
        applyStimulus(1'b1, 16'h7777);
        idle(5);
        pulseReset();
        idle(40);
        checkOutput("rst_acks", 32'(ackSeen), 32'd0);

        // Leading-zero patterns, then repeating an unchanged value.
        ackSeen = 0;
        applyStimulus(1'b1, 16'h0070);
        idle(36);
        applyStimulus(1'b1, 16'h0000);
        idle(36);
        applyStimulus(1'b1, 16'h0000);
        idle(36);
        checkOutput("lz_acks", 32'(ackSeen), 32'd3);

        // Random loads, biased towards values with leading zeros.
        for (int i = 0; i < 600; i++) begin
            logic [15:0] v;
            v = 16'($urandom);
            if ($urandom_range(0, 2) == 0) v = v & 16'h00FF;
            applyStimulus($urandom_range(0, 9) == 0, v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
